// File: rtl/inst_fetch_buffer.sv
// Prefetching instruction fetch buffer for the RiSC-16 core: streams sequential
// words from instruction memory over req/ack into a small FIFO of {inst, pc}.
module inst_fetch_buffer #(
  parameter int                    p_WORD_LEN = 16,
  parameter int                    p_DEPTH    = 4,
  parameter logic [p_WORD_LEN-1:0] p_RESET_PC = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_redirect,
  input  logic [p_WORD_LEN-1:0] i_redirect_pc,
  input  logic                  i_stall,
  output logic [p_WORD_LEN-1:0] o_inst,
  output logic [p_WORD_LEN-1:0] o_inst_pc,
  output logic                  o_inst_valid,
  output logic                  o_imem_req,
  output logic [p_WORD_LEN-1:0] o_imem_addr,
  input  logic                  i_imem_ack,
  input  logic [p_WORD_LEN-1:0] i_imem_data
);

  localparam int PTR_W = $clog2(p_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(p_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [p_WORD_LEN-1:0]   fetch_pc, fetch_pc_nxt;
  logic [p_WORD_LEN-1:0]   fifo_inst [p_DEPTH];
  logic [p_WORD_LEN-1:0]   fifo_pc   [p_DEPTH];
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [CNT_W-1:0]        count, count_after;
  logic                    req_q;
  logic                    push, pop, flush;

  assign o_inst_valid = (count != '0);
  assign o_inst       = o_inst_valid ? fifo_inst[rd_ptr] : '0;
  assign o_inst_pc    = o_inst_valid ? fifo_pc[rd_ptr]   : '0;
  assign o_imem_req   = req_q;
  assign o_imem_addr  = fetch_pc;

  // A redirect kills the head, so it can never be consumed in the same cycle.
  assign pop         = o_inst_valid & ~i_stall & ~i_redirect;
  assign count_after = count + CNT_W'(1) - CNT_W'(pop);

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    flush        = 1'b0;
    case (state)
      IDLE: begin
        if (i_redirect) begin
          flush        = 1'b1;
          fetch_pc_nxt = i_redirect_pc;
          state_nxt    = REQ;
        end else if (count < DEPTH_C) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (i_redirect) begin
          flush        = 1'b1;
          fetch_pc_nxt = i_redirect_pc;
          state_nxt    = i_imem_ack ? REQ : DRAIN;
        end else if (i_imem_ack) begin
          push         = 1'b1;
          fetch_pc_nxt = fetch_pc + p_WORD_LEN'(1);
          state_nxt    = (count_after < DEPTH_C) ? REQ : IDLE;
        end
      end
      DRAIN: begin
        // The stale request must still complete; its data is thrown away.
        if (i_redirect) begin
          flush        = 1'b1;
          fetch_pc_nxt = i_redirect_pc;
        end
        if (i_imem_ack) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      fetch_pc <= p_RESET_PC;
      req_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_q    <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= i_imem_data;
      fifo_pc[wr_ptr]   <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Randomized self-checking bench for inst_fetch_buffer: a variable-latency memory
// model plus a queue-based model of the expected instruction stream.
module tb_inst_fetch_buffer;

  localparam int         WL       = 16;
  localparam int         DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect;
  logic [WL-1:0] redirect_pc;
  logic          stall;
  logic [WL-1:0] inst;
  logic [WL-1:0] inst_pc;
  logic          inst_valid;
  logic          imem_req;
  logic [WL-1:0] imem_addr;
  logic          imem_ack;
  logic [WL-1:0] imem_data;

  inst_fetch_buffer #(
    .p_WORD_LEN (WL),
    .p_DEPTH    (DEPTH),
    .p_RESET_PC (RESET_PC)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_stall       (stall),
    .o_inst        (inst),
    .o_inst_pc     (inst_pc),
    .o_inst_valid  (inst_valid),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ack    (imem_ack),
    .i_imem_data   (imem_data)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int error_count = 0;

  // Expected stream: PCs fetched and not yet consumed, in order.
  logic [15:0] exp_q[$];
  logic [15:0] model_fetch_pc;
  logic        stale;
  int          wait_cnt;
  int          cur_lat;
  int          lat_fixed;
  logic        prev_pending;
  logic [15:0] prev_addr;
  logic        last_popped;
  logic [15:0] last_pop_pc;

  function automatic logic [15:0] mem_word(input logic [15:0] addr);
    logic [31:0] t;
    t = {16'h0, addr} * 32'h0000_3B9D;
    return t[15:0] ^ 16'hA5C3;
  endfunction

  function automatic int pick_lat();
    return (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    exp_q.delete();
    model_fetch_pc = RESET_PC;
    stale          = 1'b0;
    wait_cnt       = 0;
    cur_lat        = pick_lat();
    prev_pending   = 1'b0;
    prev_addr      = '0;
    last_popped    = 1'b0;
    last_pop_pc    = '0;
  endtask

  task automatic doReset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    stall       = 1'b0;
    imem_ack    = 1'b0;
    imem_data   = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    resetModel();
  endtask

  // Call at a negedge: drives one cycle of inputs, checks, then advances the model.
  task automatic applyStimulus(input logic st, input logic rd, input logic [15:0] rpc);
    logic        ack;
    logic        good_ack;
    logic        model_valid;
    logic [31:0] r;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    ack         = imem_req && (wait_cnt >= cur_lat);
    r           = $urandom;
    imem_ack    = ack;
    imem_data   = ack ? mem_word(imem_addr) : r[15:0];
    #1;
    model_valid = (exp_q.size() != 0);
    checkOutput("inst_valid", 32'(inst_valid), 32'(model_valid));
    if (model_valid) begin
      checkOutput("inst_pc", 32'(inst_pc), 32'(exp_q[0]));
      checkOutput("inst", 32'(inst), 32'(mem_word(exp_q[0])));
    end else begin
      checkOutput("inst_empty", 32'(inst), 32'h0);
      checkOutput("inst_pc_empty", 32'(inst_pc), 32'h0);
    end
    if (prev_pending) begin
      checkOutput("req_held", 32'(imem_req), 32'h1);
      checkOutput("addr_held", 32'(imem_addr), 32'(prev_addr));
    end
    good_ack = ack && !rd && !stale;
    if (good_ack) begin
      checkOutput("imem_addr", 32'(imem_addr), 32'(model_fetch_pc));
      checkOutput("fifo_room", 32'(exp_q.size() < DEPTH), 32'h1);
    end
    last_popped = model_valid && !st && !rd;
    last_pop_pc = inst_pc;
    if (rd) begin
      exp_q.delete();
      model_fetch_pc = rpc;
      stale          = imem_req && !ack;
    end else begin
      if (last_popped) void'(exp_q.pop_front());
      if (ack && stale) stale = 1'b0;
      else if (good_ack) begin
        exp_q.push_back(model_fetch_pc);
        model_fetch_pc = model_fetch_pc + 16'h1;
      end
    end
    prev_pending = imem_req && !ack && !rd;
    prev_addr    = imem_addr;
    if (ack) begin
      wait_cnt = 0;
      cur_lat  = pick_lat();
    end else if (imem_req) begin
      wait_cnt++;
    end
  endtask

  task automatic step(input logic st, input logic rd, input logic [15:0] rpc);
    @(negedge clk);
    applyStimulus(st, rd, rpc);
  endtask

  // Runs unstalled until n pops are seen or the cycle budget runs out.
  task automatic expectPops(input string tag, input logic [15:0] first_pc,
                            input int n, input int budget);
    int          got;
    logic [15:0] exp_pc;
    got    = 0;
    exp_pc = first_pc;
    for (int c = 0; c < budget && got < n; c++) begin
      step(1'b0, 1'b0, 16'h0);
      if (last_popped) begin
        checkOutput(tag, 32'(last_pop_pc), 32'(exp_pc));
        exp_pc = exp_pc + 16'h1;
        got++;
      end
    end
    if (got < n) checkOutput({tag, "_timeout"}, 32'(got), 32'(n));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic        done;

    // Zero-wait memory: one word per cycle right after reset.
    lat_fixed = 0;
    doReset();
    checkOutput("rst_valid", 32'(inst_valid), 32'h0);
    checkOutput("rst_req", 32'(imem_req), 32'h0);
    step(1'b0, 1'b0, 16'h0);
    checkOutput("req_before_edge", 32'(imem_req), 32'h0);
    step(1'b0, 1'b0, 16'h0);
    checkOutput("req_after_rst", 32'(imem_req), 32'h1);
    expectPops("stream_pc", RESET_PC, 8, 9);

    // Stall fills the FIFO and freezes the head; release streams without gaps.
    doReset();
    step(1'b0, 1'b0, 16'h0);
    for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 16'h0);
    checkOutput("full_req_drop", 32'(imem_req), 32'h0);
    checkOutput("frozen_pc", 32'(inst_pc), 32'(RESET_PC));
    checkOutput("frozen_inst", 32'(inst), 32'(mem_word(RESET_PC)));
    expectPops("unstall_pc", RESET_PC, 12, 16);

    // Redirect while a slow request is outstanding.
    lat_fixed = 3;
    doReset();
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (imem_req && wait_cnt == 1) begin
        applyStimulus(1'b0, 1'b1, 16'h0040);
        done = 1'b1;
      end else begin
        applyStimulus(1'b0, 1'b0, 16'h0);
      end
    end
    checkOutput("drain_redirect_seen", 32'(done), 32'h1);
    expectPops("drain_pc", 16'h0040, 3, 30);

    // Redirect coinciding with the ack of addr 5, two entries buffered.
    lat_fixed = 0;
    doReset();
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 16'h0005) begin
        checkOutput("pre_redir_valid", 32'(inst_valid), 32'h1);
        applyStimulus(1'b0, 1'b1, 16'h0010);
        done = 1'b1;
      end else begin
        applyStimulus(c < 3, 1'b0, 16'h0);
      end
    end
    checkOutput("ack_redirect_seen", 32'(done), 32'h1);
    step(1'b0, 1'b0, 16'h0);
    checkOutput("valid_after_redir", 32'(inst_valid), 32'h0);
    expectPops("redir_pc", 16'h0010, 2, 6);

    // Fetch address wraps past 16'hFFFF.
    step(1'b0, 1'b1, 16'hFFFE);
    expectPops("wrap_pc", 16'hFFFE, 4, 8);

    // Asynchronous reset in the middle of a pending request.
    lat_fixed = 3;
    doReset();
    repeat (3) step(1'b0, 1'b0, 16'h0);
    @(negedge clk);
    imem_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_req", 32'(imem_req), 32'h0);
    checkOutput("async_rst_valid", 32'(inst_valid), 32'h0);
    checkOutput("async_rst_inst", 32'(inst), 32'h0);
    checkOutput("async_rst_pc", 32'(inst_pc), 32'h0);
    #13 rst = 1'b0;
    lat_fixed = 0;
    resetModel();
    expectPops("restart_pc", RESET_PC, 3, 8);

    // Random mix of stalls, redirects and memory latencies.
    lat_fixed = -1;
    doReset();
    for (int c = 0; c < 2000; c++) begin
      r = $urandom;
      step(r[7:0] < 8'd77, r[15:8] < 8'd10, r[16] ? 16'hFFFD : r[31:16]);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- Prefetching instruction fetch unit directly upstream of the pipelined RiSC-16 core; drives the core's instruction input.
- Issues sequential word-address requests to an instruction memory over a req/ack handshake and buffers returned words with their PCs in a small FIFO.
- Presents the FIFO head to the core's fetch stage, holds it while the core stalls fetch, and flushes on a redirect (taken BEQ/JALR).

Parameters:
p_WORD_LEN, 16, instruction and PC width
p_DEPTH, 4, FIFO entries; power of two, >= 2
p_RESET_PC, 16'h0000, first fetch address after reset

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  asynchronous, active-high reset
i_redirect  in  1  core requests fetch restart at i_redirect_pc
i_redirect_pc  in  p_WORD_LEN  new fetch address
i_stall  in  1  core fetch stage stalled; head must not be consumed
o_inst  out  p_WORD_LEN  FIFO head instruction; 16'h0000 (ADD r0,r0,r0 = NOP) when empty
o_inst_pc  out  p_WORD_LEN  PC of o_inst; 0 when empty
o_inst_valid  out  1  FIFO non-empty
o_imem_req  out  1  instruction memory request
o_imem_addr  out  p_WORD_LEN  request address; stable while o_imem_req high and unacked
i_imem_ack  in  1  memory accepts the request; i_imem_data valid this cycle
i_imem_data  in  p_WORD_LEN  instruction word returned with ack

Behaviour:
- Reset (async, any time, including mid-request): FIFO empty, count 0, fetch_pc = p_RESET_PC, state IDLE, o_imem_req 0, o_inst_valid 0, o_inst 0, o_inst_pc 0. A request outstanding at reset is abandoned; the memory model must tolerate this.
- o_imem_addr = fetch_pc register. o_imem_req = (state != IDLE), registered.
- Pop = o_inst_valid & ~i_stall & ~i_redirect. Head advances on pop at the rising edge.
- Outputs o_inst, o_inst_pc, o_inst_valid come combinationally from FIFO head and count. They are zero when empty.
- States:
  - IDLE: no request. If i_redirect: flush, fetch_pc <= i_redirect_pc, go REQ. Else if count < p_DEPTH: go REQ.
  - REQ: request live. A same-cycle ack is allowed, including in the first req cycle.
    - Ack and no redirect: push {i_imem_data, fetch_pc}; fetch_pc <= fetch_pc + 1 (mod 2^16, 16'hFFFF wraps to 0). Stay REQ if count + 1 - pop < p_DEPTH, else go IDLE.
    - Redirect with ack: discard data, flush, fetch_pc <= i_redirect_pc, stay REQ.
    - Redirect without ack: flush, fetch_pc <= i_redirect_pc, go DRAIN.
  - DRAIN: stale request still held. Req stays high and o_imem_addr stays on the new fetch_pc; the memory is address-insensitive until ack per protocol, so the address change is legal only here.
    - Ack: discard data, go REQ.
    - Redirect: update fetch_pc, stay DRAIN.
- Redirect priority: a redirect overrides push and pop in the same cycle. FIFO count is 0 at the next edge, so o_inst_valid is 0 in the cycle after a redirect.
- Push and pop in the same cycle: count unchanged. A push never occurs when count == p_DEPTH, because no request is issued.
- Zero-wait memory (ack tied high): one instruction per cycle sustained. Minimum latency: req cycle N, o_inst_valid in cycle N+1.
- A stalled head holds o_inst and o_inst_pc unchanged for as long as i_stall is high.

Test Plan:
- Reset release, ack tied 1, no stall -> o_imem_req high 1 cycle after release. o_inst_pc sequence 0,1,2,3... one per cycle. o_inst equals the memory contents at each PC.
- i_stall held 6 cycles with ack=1 -> FIFO fills to 4, o_imem_req drops, o_inst/o_inst_pc frozen. On release, 4 buffered then new words stream in order with no gaps or duplicates.
- Memory with 3-cycle ack latency, i_redirect to 16'h0040 in the 2nd wait cycle -> state DRAIN. The stale ack's data is dropped. Next request addr 16'h0040; first valid o_inst_pc = 16'h0040.
- i_redirect to 16'h0010 in the same cycle as ack of addr 5 with FIFO holding 2 entries -> valid 0 next cycle. Addr-5 data never appears. Next outputs have PCs 0x10, 0x11.
- Redirect to 16'hFFFE, ack=1 -> o_inst_pc sequence FFFE, FFFF, 0000, 0001.
- Assert i_rst asynchronously mid-REQ (not on an edge) -> outputs zero immediately. After release, fetch restarts at p_RESET_PC with an empty FIFO.
